// File: rtl/srt4_otf_converter.sv
// On-the-fly conversion of signed radix-4 quotient digits (MSD first) into Q and QM = Q - 1 ulp.
// State | meaning: IDLE | waiting for start; ACCUM | accepting digits; DONE | one-cycle result pulse
module srt4_otf_converter #(
  parameter int WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  digit_valid,
  output logic                                  digit_ready,
  input  logic                                  digit_sign,
  input  logic [1:0]                            digit_mag,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic [$clog2(WIDTH/2+1)-1:0]          digit_cnt,
  output logic [WIDTH-1:0]                      quotient,
  output logic [WIDTH-1:0]                      quotient_m1
);
  localparam int NDIGITS = WIDTH / 2;
  localparam int CW      = $clog2(NDIGITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIGITS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state;

  logic             accept;
  logic             digit_zero;
  logic             illegal;
  logic [1:0]       q_lo;
  logic [1:0]       qm_lo;
  logic [WIDTH-3:0] q_src;
  logic [WIDTH-3:0] qm_src;

  assign accept     = digit_valid & digit_ready & ~start;
  assign illegal    = (digit_mag == 2'd3);
  assign digit_zero = (digit_mag == 2'd0) | illegal;

  // Positive digits extend Q; negative digits borrow from QM; zero keeps each register's own prefix.
  always_comb begin
    q_lo   = 2'd0;
    qm_lo  = 2'd3;
    q_src  = quotient[WIDTH-3:0];
    qm_src = quotient_m1[WIDTH-3:0];
    if (!digit_zero) begin
      if (!digit_sign) begin
        q_lo   = digit_mag;
        qm_lo  = digit_mag - 2'd1;
        qm_src = quotient[WIDTH-3:0];
      end else begin
        q_lo   = 2'd0 - digit_mag;
        qm_lo  = 2'd3 - digit_mag;
        q_src  = quotient_m1[WIDTH-3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      quotient    <= '0;
      quotient_m1 <= '1;
      digit_cnt   <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      digit_ready <= 1'b0;
      done        <= 1'b0;
    end else if (start) begin
      state       <= ACCUM;
      quotient    <= '0;
      quotient_m1 <= '1;
      digit_cnt   <= '0;
      err         <= 1'b0;
      busy        <= 1'b1;
      digit_ready <= 1'b1;
      done        <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            quotient    <= {q_src, q_lo};
            quotient_m1 <= {qm_src, qm_lo};
            digit_cnt   <= digit_cnt + 1'b1;
            if (illegal) err <= 1'b1;
            if (digit_cnt == LAST_CNT) begin
              state       <= DONE;
              busy        <= 1'b0;
              digit_ready <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          digit_ready <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_srt4_otf_converter.sv
// Bench for srt4_otf_converter: arithmetic reference (Q = 4*Q + q mod 2^W) checked every cycle,
// directed scenarios with literal expectations, then randomized conversions.
module tb_srt4_otf_converter;
  localparam int WIDTH   = 8;
  localparam int NDIGITS = WIDTH / 2;
  localparam int CW      = $clog2(NDIGITS + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             digit_valid = 1'b0;
  logic             digit_sign = 1'b0;
  logic [1:0]       digit_mag = 2'd0;
  logic             digit_ready, busy, done, err;
  logic [CW-1:0]    digit_cnt;
  logic [WIDTH-1:0] quotient, quotient_m1;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  srt4_otf_converter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .digit_valid(digit_valid),
    .digit_ready(digit_ready), .digit_sign(digit_sign), .digit_mag(digit_mag),
    .busy(busy), .done(done), .err(err), .digit_cnt(digit_cnt),
    .quotient(quotient), .quotient_m1(quotient_m1)
  );

  always #5 clk = ~clk;

  // Reference: the quotient is just the running value sum(q_i * 4^k) modulo 2^WIDTH.
  int               m_phase;   // 0 idle, 1 accumulating, 2 result pulse
  logic [WIDTH-1:0] m_q;
  int               m_cnt;
  logic             m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_q = '0; m_cnt = 0; m_err = 1'b0;
    end else if (start) begin
      m_phase = 1; m_q = '0; m_cnt = 0; m_err = 1'b0;
    end else if (m_phase == 1) begin
      if (digit_valid) begin
        int q;
        q = (digit_mag == 2'd3) ? 0 : (digit_sign ? -int'(digit_mag) : int'(digit_mag));
        m_q = m_q * WIDTH'(4) + WIDTH'(q);
        m_cnt++;
        if (digit_mag == 2'd3) m_err = 1'b1;
        if (m_cnt == NDIGITS) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("quotient", 32'(quotient), 32'(m_q));
    chk("quotient_m1", 32'(quotient_m1), 32'(WIDTH'(m_q - WIDTH'(1))));
    chk("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_phase == 1));
    chk("digit_ready", 32'(digit_ready), 32'(m_phase == 1));
    chk("done", 32'(done), 32'(m_phase == 2));
    chk("err", 32'(err), 32'(m_err));
    if (done) done_seen++;
  end

  task automatic cyc(input logic s, input logic v, input int q);
    start       = s;
    digit_valid = v;
    digit_sign  = (q < 0);
    digit_mag   = (q == 3) ? 2'd3 : 2'((q < 0) ? -q : q);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0);
  endtask

  int done_base;

  initial begin
    idle(2);
    chk("reset_q", 32'(quotient), 32'h00);
    chk("reset_qm", 32'(quotient_m1), 32'hFF);
    rst_n = 1'b1;
    idle(2);

    // +1,+2,0,-1 back-to-back
    cyc(1, 0, 0);
    cyc(0, 1, 1); cyc(0, 1, 2); cyc(0, 1, 0); cyc(0, 1, -1);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_q", 32'(quotient), 32'h5F);
    chk("s1_qm", 32'(quotient_m1), 32'h5E);
    idle(2);

    // -2,0,0,0 with gaps
    cyc(1, 0, 0);
    cyc(0, 1, -2); idle(2); cyc(0, 1, 0); idle(2); cyc(0, 1, 0); idle(2); cyc(0, 1, 0);
    chk("s2_q", 32'(quotient), 32'h80);
    chk("s2_qm", 32'(quotient_m1), 32'h7F);
    chk("s2_cnt", 32'(digit_cnt), 32'd4);
    idle(2);

    // -1 x4
    cyc(1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, -1);
    chk("s3_q", 32'(quotient), 32'hAB);
    chk("s3_qm", 32'(quotient_m1), 32'hAA);
    chk("s3_err", 32'(err), 32'd0);
    idle(2);

    // illegal digit makes err sticky
    cyc(1, 0, 0);
    cyc(0, 1, 1); cyc(0, 1, 3);
    chk("s4_err_early", 32'(err), 32'd1);
    cyc(0, 1, 1); cyc(0, 1, 1);
    chk("s4_q", 32'(quotient), 32'h45);
    chk("s4_err", 32'(err), 32'd1);
    idle(1);
    cyc(1, 0, 0);
    chk("s4_err_clr", 32'(err), 32'd0);

    // restart mid-conversion; digit coincident with start is dropped
    done_base = done_seen;
    cyc(0, 1, 2); cyc(0, 1, 2);
    cyc(1, 1, 2);
    chk("s5_restart_q", 32'(quotient), 32'h00);
    cyc(0, 1, 1); cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 0);
    chk("s5_q", 32'(quotient), 32'h40);
    idle(2);
    chk("s5_done_cnt", 32'(done_seen - done_base), 32'd1);

    // reset mid-conversion, then digits in IDLE are ignored
    done_base = done_seen;
    cyc(1, 0, 0);
    cyc(0, 1, 1); cyc(0, 1, -2);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_q", 32'(quotient), 32'h00);
    chk("s6_qm", 32'(quotient_m1), 32'hFF);
    chk("s6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 2); cyc(0, 1, -1);
    chk("s6_idle_q", 32'(quotient), 32'h00);
    chk("s6_idle_cnt", 32'(digit_cnt), 32'd0);
    idle(2);
    chk("s6_no_done", 32'(done_seen - done_base), 32'd0);

    // randomized conversions with gaps, illegal digits and occasional restarts
    for (int n = 0; n < 300; n++) begin
      cyc(1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 4)) - 2);
      for (int k = 0; k < 12; k++) begin
        int r, q;
        r = int'($urandom_range(0, 19));
        q = (r == 0) ? 3 : int'($urandom_range(0, 4)) - 2;
        if (r == 1) cyc(1, 1, q);
        else        cyc(0, $urandom_range(0, 3) != 0, q);
      end
      idle(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
